// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single SDRAM framebuffer command port between the VGA line
//   prefetcher (BURST-word reads) and the sprite/draw engine (single-word
//   writes). Display wins ties, except that after STARVE_MAX consecutive display
//   grants with a draw request pending, the draw request is granted.
//
// Ports
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   disp_req/disp_addr -> disp_ack  display burst request and capture pulse
//   disp_rdata/disp_rvalid/disp_done
//                                   returned read data; done on the last word
//   draw_req/draw_addr/draw_wdata -> draw_ack
//                                   draw write request and capture pulse
//   mem_addr/mem_read/mem_write/mem_wdata, mem_wait
//                                   memory command port; held while mem_wait
//   mem_rdata/mem_rvalid            in-order read returns
//   dbg_state                       current FSM state for observation
//
// Handshake: a requester holds req (and its addr/data) until the matching ack
// pulse, which is asserted combinationally in the IDLE cycle the request is
// captured. A memory command is accepted on any cycle it is presented with
// mem_wait low; while mem_wait is high it is held unchanged.
module fb_port_arbiter #(
  parameter int AW         = 20,
  parameter int DW         = 16,
  parameter int BURST      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  output logic          disp_done,
  input  logic          draw_req,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_wdata,
  output logic          draw_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_wait,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(BURST + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t        state;
  logic          armed;      // blocks grants until the first edge after reset release
  logic [AW-1:0] base_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] issued;
  logic [CW-1:0] returned;
  logic [SW-1:0] streak;     // consecutive display grants made while draw waited

  logic grant_draw;
  logic grant_disp;
  logic rd_accept;
  logic rd_last;
  logic ret_take;

  always_comb begin
    grant_draw = 1'b0;
    grant_disp = 1'b0;
    if (armed && state == IDLE) begin
      if (draw_req && (!disp_req || streak == STARVE_C)) begin
        grant_draw = 1'b1;
      end else if (disp_req) begin
        grant_disp = 1'b1;
      end
    end
  end

  assign draw_ack  = grant_draw;
  assign disp_ack  = grant_disp;
  assign rd_accept = (state == RD_ISSUE) && !mem_wait;
  assign rd_last   = rd_accept && (issued == BURST_C - CW'(1));
  // Returns count only while a burst is live; anything else (idle, write,
  // surplus words, leftovers of a burst aborted by reset) is dropped.
  assign ret_take  = mem_rvalid && (state == RD_ISSUE || state == RD_DRAIN) &&
                     (returned != BURST_C);

  assign mem_read  = (state == RD_ISSUE);
  assign mem_write = (state == WR);
  // Burst address wraps modulo 2^AW.
  assign mem_addr  = (state == RD_ISSUE) ? base_addr + AW'(issued) :
                     (state == WR)       ? wr_addr : '0;
  assign mem_wdata = (state == WR) ? wr_data : '0;
  assign dbg_state = state;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      base_addr   <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      issued      <= '0;
      returned    <= '0;
      streak      <= '0;
      disp_rdata  <= '0;
      disp_rvalid <= 1'b0;
      disp_done   <= 1'b0;
    end else begin
      armed       <= 1'b1;
      disp_rvalid <= 1'b0;
      disp_done   <= 1'b0;

      if (ret_take) begin
        disp_rdata  <= mem_rdata;
        disp_rvalid <= 1'b1;
        disp_done   <= (returned == BURST_C - CW'(1));
        returned    <= returned + CW'(1);
      end

      case (state)
        IDLE: begin
          if (grant_draw) begin
            wr_addr <= draw_addr;
            wr_data <= draw_wdata;
            streak  <= '0;
            state   <= WR;
          end else if (grant_disp) begin
            base_addr <= disp_addr;
            issued    <= '0;
            returned  <= '0;
            streak    <= draw_req ? streak + SW'(1) : '0;
            state     <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (rd_accept) begin
            issued <= issued + CW'(1);
            if (rd_last) begin
              state <= (returned == BURST_C) ? IDLE : RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (returned == BURST_C) begin
            state <= IDLE;
          end
        end
        WR: begin
          if (!mem_wait) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Drives fb_port_arbiter with queued display/draw requests and a memory
//   responder (scripted or random waitrequest, variable read latency). A
//   reference model predicts grant order from the arbitration rule, the exact
//   command sequence each grant must produce, and the display data stream.
module tb_fb_port_arbiter;

  localparam int AW         = 20;
  localparam int DW         = 16;
  localparam int BURST      = 8;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          clk_clk;
  logic          reset_reset_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          disp_done;
  logic          draw_req;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_wdata;
  logic          draw_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic          mem_wait;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [1:0]    dbg_state;

  fb_port_arbiter #(.AW(AW), .DW(DW), .BURST(BURST), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .disp_done(disp_done),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_ack(draw_ack), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wait(mem_wait),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            since_rel = 0;
  cmd_t          cmd_q[$];          // commands the model expects, in order
  logic [DW-1:0] exp_q[$];          // display data the model expects
  logic [AW-1:0] disp_pend[$];      // display requests waiting to be raised
  cmd_t          draw_pend[$];      // draw requests waiting to be raised
  int            ret_due[$];        // responder: cycle each return is due
  logic [DW-1:0] ret_dat[$];
  bit            wait_pat[$];       // scripted mem_wait, consumed on command cycles
  int            last_due = 0;
  bit            wait_rand = 0;
  int            lat_min = 1;
  int            lat_max = 1;
  int            streak = 0;
  bit            busy = 0;
  int            rx_cnt = 0;
  int            idle_wait = 0;
  byte           grant_log[$];
  bit            prev_hold = 0;
  logic          prev_rd, prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  int            wr_cycles = 0;
  int            last_wr_cycles = 0;
  int            n_reads = 0;
  int            n_writes = 0;
  bit            drop_disp = 0;
  bit            drop_draw = 0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor (negedge) ----------------
  task automatic monitor();
    cmd_t          c;
    logic [AW-1:0] a;
    int            due;
    bit            exp_draw;
    if (!reset_reset_n) begin
      check_eq("rst_outputs", {disp_ack, draw_ack, disp_rvalid, disp_done, mem_read, mem_write}, 0);
      check_eq("rst_addr", mem_addr, 0);
      prev_hold = 0;
      idle_wait = 0;
      return;
    end
    if (since_rel == 0 && (disp_req || draw_req))
      check_eq("armed_gate", {disp_ack, draw_ack}, 0);
    check_eq("rd_wr_excl", mem_read & mem_write, 0);
    if (prev_hold) begin
      check_eq("hold_read", mem_read, prev_rd);
      check_eq("hold_write", mem_write, prev_wr);
      check_eq("hold_addr", mem_addr, prev_addr);
      check_eq("hold_wdata", mem_wdata, prev_wdata);
    end
    if (mem_write) wr_cycles++;

    if (mem_read && !mem_wait) begin
      n_reads++;
      if (cmd_q.size() == 0) check_eq("rd_unexpected", cmd_q.size(), 1);
      else begin
        c = cmd_q.pop_front();
        check_eq("rd_kind", c.wr, 0);
        check_eq("rd_addr", mem_addr, c.addr);
      end
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      ret_due.push_back(due);
      ret_dat.push_back(mem_data(mem_addr));
    end
    if (mem_write && !mem_wait) begin
      n_writes++;
      last_wr_cycles = wr_cycles;
      wr_cycles = 0;
      if (cmd_q.size() == 0) check_eq("wr_unexpected", cmd_q.size(), 1);
      else begin
        c = cmd_q.pop_front();
        check_eq("wr_kind", c.wr, 1);
        check_eq("wr_addr", mem_addr, c.addr);
        check_eq("wr_data", mem_wdata, c.data);
      end
      busy = 0;
    end

    if (disp_rvalid) begin
      if (exp_q.size() == 0) check_eq("rvalid_unexpected", exp_q.size(), 1);
      else begin
        check_eq("disp_rdata", disp_rdata, exp_q.pop_front());
        rx_cnt++;
        check_eq("disp_done", disp_done, rx_cnt == BURST);
        if (rx_cnt == BURST) busy = 0;
      end
    end else if (disp_done) begin
      check_eq("done_without_rvalid", disp_done, 0);
    end

    if (disp_ack || draw_ack) begin
      check_eq("ack_excl", disp_ack & draw_ack, 0);
      check_eq("ack_while_busy", busy, 0);
      exp_draw = draw_req && (!disp_req || streak == STARVE_MAX);
      check_eq("grant_winner", draw_ack, exp_draw);
      if (draw_ack) begin
        c.wr = 1'b1; c.addr = draw_addr; c.data = draw_wdata;
        cmd_q.push_back(c);
        streak = 0;
        grant_log.push_back("W");
        drop_draw = 1;
      end else begin
        streak = draw_req ? streak + 1 : 0;
        for (int i = 0; i < BURST; i++) begin
          a = disp_addr + AW'(i);
          c.wr = 1'b0; c.addr = a; c.data = '0;
          cmd_q.push_back(c);
          exp_q.push_back(mem_data(a));
        end
        rx_cnt = 0;
        grant_log.push_back("D");
        drop_disp = 1;
      end
      busy = 1;
      idle_wait = 0;
    end else if (!busy && (disp_req || draw_req) && since_rel > 0) begin
      idle_wait++;
      if (idle_wait > 3) check_eq("grant_stall", idle_wait, 3);
    end

    prev_hold  = (mem_read || mem_write) && mem_wait;
    prev_rd    = mem_read;
    prev_wr    = mem_write;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  endtask

  // ---------------- driver (posedge + 1) ----------------
  task automatic drive();
    cmd_t c;
    cyc++;
    since_rel++;
    if (drop_disp) begin disp_req = 1'b0; drop_disp = 0; end
    if (drop_draw) begin draw_req = 1'b0; drop_draw = 0; end
    if (!disp_req && disp_pend.size() > 0) begin
      disp_addr = disp_pend.pop_front();
      disp_req  = 1'b1;
    end
    if (!draw_req && draw_pend.size() > 0) begin
      c = draw_pend.pop_front();
      draw_addr  = c.addr;
      draw_wdata = c.data;
      draw_req   = 1'b1;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
      void'(ret_due.pop_front());
      mem_rvalid = 1'b1;
      mem_rdata  = ret_dat.pop_front();
    end
    if (wait_pat.size() > 0 && (mem_read || mem_write)) mem_wait = wait_pat.pop_front();
    else mem_wait = wait_rand && ($urandom_range(0, 3) == 0);
  endtask

  task automatic cycle_step();
    @(negedge clk_clk);
    monitor();
    @(posedge clk_clk);
    #1;
    drive();
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    while ((busy || disp_req || draw_req || disp_pend.size() > 0 || draw_pend.size() > 0 ||
            ret_due.size() > 0 || cmd_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle_step();
      n++;
    end
    if (n >= budget)
      check_eq({tag, "_timeout"}, cmd_q.size() + exp_q.size() + ret_due.size() + int'(busy), 0);
    repeat (2) cycle_step();
  endtask

  task automatic push_draw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.wr = 1'b1; c.addr = a; c.data = d;
    draw_pend.push_back(c);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int    r0;
    int    w0;
    int    budget;
    string exp_s;

    reset_reset_n = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    draw_req = 1'b0; draw_addr = '0; draw_wdata = '0;
    mem_wait = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) cycle_step();
    reset_reset_n = 1'b1;
    since_rel = 0;
    repeat (2) cycle_step();

    // Display only, fixed 2-cycle read latency.
    lat_min = 2; lat_max = 2; wait_rand = 0;
    r0 = n_reads;
    disp_pend.push_back(20'h00100);
    run_idle(200, "disp_only");
    check_eq("disp_only_reads", n_reads - r0, BURST);
    check_eq("disp_only_idle", mem_read, 0);

    // Draw only, mem_wait high for three command cycles.
    w0 = n_writes;
    wait_pat = '{1'b1, 1'b1, 1'b1};
    push_draw(20'h0ABCD, 16'h1234);
    run_idle(100, "draw_only");
    check_eq("draw_only_writes", n_writes - w0, 1);
    check_eq("draw_hold_cycles", last_wr_cycles, 4);

    // Both requesters continuously asserting.
    lat_min = 1; lat_max = 1;
    grant_log.delete();
    for (int i = 0; i < 8; i++) disp_pend.push_back(AW'(20'h01000 + i * 16));
    push_draw(20'h00010, 16'hAAAA);
    push_draw(20'h00020, 16'h5555);
    run_idle(800, "starve");
    exp_s = "DDDDWDDDDW";
    check_eq("starve_count", grant_log.size(), exp_s.len());
    for (int i = 0; i < exp_s.len() && i < grant_log.size(); i++)
      check_eq("starve_order", grant_log[i], exp_s[i]);

    // Address wrap at the top of the address space.
    lat_min = 1; lat_max = 3;
    disp_pend.push_back(20'hFFFFC);
    run_idle(200, "wrap");

    // Scripted waitrequest mid-burst.
    r0 = n_reads;
    wait_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    disp_pend.push_back(20'h00400);
    run_idle(200, "wait_toggle");
    check_eq("wait_toggle_reads", n_reads - r0, BURST);

    // Reset in the middle of a burst; late returns must be dropped.
    lat_min = 6; lat_max = 6; wait_rand = 0;
    r0 = n_reads;
    disp_pend.push_back(20'h00300);
    budget = 0;
    while (n_reads < r0 + 3 && budget < 50) begin cycle_step(); budget++; end
    check_eq("abort_reads_issued", n_reads - r0, 3);
    reset_reset_n = 1'b0;
    cmd_q.delete(); exp_q.delete(); disp_pend.delete(); draw_pend.delete();
    busy = 0; streak = 0; prev_hold = 0; drop_disp = 0; drop_draw = 0;
    disp_req = 1'b0;
    draw_req = 1'b1; draw_addr = 20'h00077; draw_wdata = 16'hBEEF;
    repeat (2) cycle_step();
    reset_reset_n = 1'b1;
    since_rel = 0;
    check_eq("stale_pending", ret_due.size() >= 2, 1);
    run_idle(200, "after_abort");
    lat_min = 2; lat_max = 2;
    r0 = n_reads;
    disp_pend.push_back(20'h00200);
    run_idle(200, "post_reset_burst");
    check_eq("post_reset_reads", n_reads - r0, BURST);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; wait_rand = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) != 0 && disp_pend.size() < 3)
        disp_pend.push_back(AW'($urandom));
      if ($urandom_range(0, 1) != 0 && draw_pend.size() < 3)
        push_draw(AW'($urandom), DW'($urandom));
      repeat ($urandom_range(1, 25)) cycle_step();
    end
    run_idle(3000, "random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
